// File: rtl/round_robin_dispatcher_to_2_consumers.sv
// Fans one valid/ready stream out to two consumers in round-robin order.
// Each lane has its own small FIFO, so a stalled consumer only blocks its own lane.
module round_robin_dispatcher_to_2_consumers #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              up_ready,
    output logic [1:0]        dn_valid,
    output logic [DATA_W-1:0] dn_data0,
    output logic [DATA_W-1:0] dn_data1,
    input  logic [1:0]        dn_ready,
    output logic [CNT_W-1:0]  lane_cnt0,
    output logic [CNT_W-1:0]  lane_cnt1
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic              next_lane_q, next_lane_d;
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  cnt_q    [2];
    logic [CNT_W-1:0]  cnt_d    [2];
    logic [DATA_W-1:0] mem_q    [2][DEPTH];

    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic       accept;
    logic       target;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i] = (cnt_q[i] == CNT_W'(DEPTH));
            pop[i]  = (cnt_q[i] != '0) && dn_ready[i];
        end
        accept = up_valid && !(full[0] && full[1]);
        // A full preferred lane is skipped; the pointer then returns to it first.
        target = full[next_lane_q] ? ~next_lane_q : next_lane_q;
        push = '0;
        if (accept) begin
            push[target] = 1'b1;
        end
        next_lane_d = accept ? ~target : next_lane_q;
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_lane_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            next_lane_q <= next_lane_d;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    // Storage needs no reset: contents are only visible while the count is non-zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= up_data;
            end
        end
    end

    assign up_ready  = !(full[0] && full[1]);
    assign dn_valid  = {cnt_q[1] != '0, cnt_q[0] != '0};
    assign dn_data0  = mem_q[0][rd_ptr_q[0]];
    assign dn_data1  = mem_q[1][rd_ptr_q[1]];
    assign lane_cnt0 = cnt_q[0];
    assign lane_cnt1 = cnt_q[1];

endmodule

// File: doc/round_robin_dispatcher_to_2_consumers.md
Name: round_robin_dispatcher_to_2_consumers

Overview:
Distributes one upstream valid/ready stream across two downstream consumers in round-robin order. It is the counterpart of the 2-request round-robin arbiter: the arbiter merges two requesters onto one resource, and this block fans one producer out to two resources. Each lane has a small registered FIFO so that one slow consumer does not stall the other. It sits between a single work source and two parallel processing lanes.

Parameters:
DATA_W, 8, width of the payload word
DEPTH, 2, entries per lane FIFO; must be a power of two and at least 2
CNT_W, $clog2(DEPTH+1), width of the per-lane occupancy outputs (derived; do not override)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  reset, asynchronous and active-high
up_valid  input  1  upstream word available
up_data  input  DATA_W  upstream payload
up_ready  output  1  block can accept a word this cycle
dn_valid  output  2  bit i is high when lane i has a word at its head
dn_data0  output  DATA_W  head word of lane 0
dn_data1  output  DATA_W  head word of lane 1
dn_ready  input  2  bit i is high when consumer i accepts its head word
lane_cnt0  output  CNT_W  current lane 0 occupancy
lane_cnt1  output  CNT_W  current lane 1 occupancy

Behaviour:
- State:
  - one-bit next_lane pointer.
  - per lane: a DEPTH-entry memory, wr_ptr, rd_ptr, and count.
- Reset (async assert; synchronous-safe deassert assumed by the system):
  - next_lane=0, all pointers and counts = 0.
  - dn_valid=2'b00, up_ready=1, lane_cnt0 = lane_cnt1 = 0.
  - dn_data values are don't-care while dn_valid=0.
- full_i = (count_i == DEPTH). up_ready = !full_0 || !full_1, combinational from registered counts only; it never depends on dn_ready.
- Target lane selection (combinational, evaluated when up_valid && up_ready):
  - next_lane not full -> target = next_lane.
  - next_lane full -> target = the other lane (guaranteed not full because up_ready=1).
- Push: on accept, write up_data into the target lane; next_lane <= ~target.
  - When both lanes have room, targets strictly alternate 0,1,0,1.
  - When one lane is full, words go to the free lane; the pointer then points back at the full lane so it is retried first.
- Pop: lane i pops when dn_valid[i] && dn_ready[i]; rd_ptr_i increments with wrap at DEPTH.
- Latency: a word accepted in cycle N appears on dn_valid/dn_data of its lane in cycle N+1. There is no bypass path.
- Simultaneous push and pop on the same lane: count is unchanged and both pointers advance.
- A pop in cycle N frees space only from cycle N+1. A full lane is not writable in the same cycle it pops.
- Pointer wrap: wr_ptr and rd_ptr wrap modulo DEPTH. Ordering within a lane is strict FIFO.
- dn_ready without dn_valid has no effect. up_valid while up_ready=0 has no effect, and the pointer holds.
- dn_valid[i] = (count_i != 0). dn_data_i = mem_i[rd_ptr_i]. lane_cnt_i = count_i.
- Reset asserted mid-operation: all stored words are discarded and the state returns immediately to reset values. The first accepted word after reset goes to lane 0.

Test Plan:
- Reset, then dn_ready=2'b11 with a continuous up_valid stream 0x01..0x06 -> lane 0 outputs 0x01,0x03,0x05; lane 1 outputs 0x02,0x04,0x06; each word appears one cycle after acceptance; up_ready stays 1.
- dn_ready=2'b10, DEPTH=2, stream 0x01..0x06 -> lane 0 holds 0x01,0x03 (lane_cnt0=2); lane 1 outputs 0x02,0x04,0x05,0x06 in order; up_ready stays 1.
- dn_ready=2'b00, push 5 words 0x0A..0x0E -> first 4 accepted (0x0A,0x0C in lane 0; 0x0B,0x0D in lane 1); up_ready=0 for 0x0E. Then raise dn_ready[1] for one cycle -> 0x0E is accepted in the following cycle into lane 1.
- Lane 0 full while lane 0 pops in the same cycle that up_valid=1 -> the word goes to lane 1 that cycle; lane_cnt0 drops to 1 only in the next cycle.
- Assert rst asynchronously mid-stream with lane_cnt0=2 and lane_cnt1=1 -> dn_valid=0 and counts=0 without waiting for a clock edge. The next accepted word (0x55) appears on lane 0.
- Run a long random up_valid/dn_ready sequence against a scoreboard model -> no loss, no duplication, per-lane order preserved, and lane choice matches the round-robin/skip rule on every accept.
